// File: rtl/video_pkg.sv
// Shared definitions for the video level clamp: ADC width, lock/timeout
// constants, the clamp FSM state type and the IIR level-update helper.
package video_pkg;

  localparam int ADC_W        = 12;
  localparam int LOCK_LINES   = 4;
  localparam int LINE_TIMEOUT = 4096;

  typedef enum logic [1:0] {
    ST_SEEK    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_PORCH   = 2'd2,
    ST_MEASURE = 2'd3
  } clamp_state_e;

  // One-eighth step from the current level toward a new window average.
  // The difference is signed and shifted arithmetically, so a falling level
  // rounds toward minus infinity; the result always lies between the two inputs.
  function automatic logic [ADC_W-1:0] iir_step(input logic [ADC_W-1:0] cur,
                                                input logic [ADC_W-1:0] avg);
    logic signed [ADC_W:0] diff;
    logic signed [ADC_W:0] nxt;
    diff = $signed({1'b0, avg}) - $signed({1'b0, cur});
    nxt  = $signed({1'b0, cur}) + (diff >>> 3);
    return nxt[ADC_W-1:0];
  endfunction

endpackage

// File: rtl/video_level_clamp_window_averager.sv
// Window averager: sums 2^WIN_LOG2 enabled samples and reports the average
// combinationally on the cycle the last sample arrives. clear_i drops any
// partial window and takes priority over sample_en_i.
module window_averager
  import video_pkg::*;
#(
  parameter int WIN_LOG2 = 5
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             clear_i,
  input  logic             sample_en_i,
  input  logic [ADC_W-1:0] sample_i,
  output logic             done_o,
  output logic [ADC_W-1:0] avg_o
);

  localparam int ACC_W = ADC_W + WIN_LOG2;

  logic [ACC_W-1:0]    acc_q, acc_d, sum;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic                last;

  assign sum    = acc_q + ACC_W'(sample_i);
  assign last   = (cnt_q == '1);
  assign done_o = sample_en_i && !clear_i && last;
  assign avg_o  = sum[ACC_W-1:WIN_LOG2];

  // Next accumulator/count: clear, accumulate, or restart after the last sample.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_en_i) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + WIN_LOG2'(1);
      end
    end
  end

  // Accumulator and sample-count registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/video_level_clamp.sv
// Video level clamp: finds horizontal sync, waits out the back porch, averages
// a window of blanking samples to track the blank level, and outputs each
// sample relative to that level.
// Build option: define LEVEL_IIR_EN to move the blank level 1/8 of the way
// toward each new window average instead of replacing it outright.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_SEEK    | waiting for a sample below SYNC_THRESH
// ST_SYNC    | inside a low run; run_q counts its length (saturating)
// ST_PORCH   | valid sync seen; counting down the porch before measuring
// ST_MEASURE | accumulating the blank-level window
module video_level_clamp
  import video_pkg::*;
#(
  parameter logic [ADC_W-1:0] SYNC_THRESH  = 12'd600,
  parameter int               SYNC_MIN_LEN = 64,
  parameter int               SYNC_MAX_LEN = 256,
  parameter int               PORCH_DELAY  = 120,
  parameter int               WIN_LOG2     = 5,
  parameter logic [ADC_W-1:0] BLANK_INIT   = 12'd2048
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    sample_valid,
  input  logic [ADC_W-1:0]        adc_in,
  output logic signed [ADC_W:0]   video_out,
  output logic                    video_valid,
  output logic                    sync_tip,
  output logic [ADC_W-1:0]        blank_level,
  output logic                    level_locked
);

  localparam int RUN_W   = $clog2(SYNC_MAX_LEN + 2);
  localparam int PORCH_W = (PORCH_DELAY > 1) ? $clog2(PORCH_DELAY) : 1;
  localparam int GOOD_W  = $clog2(LOCK_LINES + 1);
  localparam int TMO_W   = $clog2(LINE_TIMEOUT + 1);

  localparam logic [RUN_W-1:0]   RUN_ONE    = RUN_W'(1);
  localparam logic [RUN_W-1:0]   RUN_MIN    = RUN_W'(SYNC_MIN_LEN);
  localparam logic [RUN_W-1:0]   RUN_MAX    = RUN_W'(SYNC_MAX_LEN);
  localparam logic [RUN_W-1:0]   RUN_SAT    = RUN_W'(SYNC_MAX_LEN + 1);
  localparam logic [PORCH_W-1:0] PORCH_LOAD = PORCH_W'((PORCH_DELAY > 1) ? PORCH_DELAY - 1 : 0);
  localparam logic [PORCH_W-1:0] PORCH_ONE  = PORCH_W'(1);
  localparam logic [GOOD_W-1:0]  GOOD_SAT   = GOOD_W'(LOCK_LINES);
  localparam logic [TMO_W-1:0]   TMO_SAT    = TMO_W'(LINE_TIMEOUT);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LINE_TIMEOUT - 1);

  clamp_state_e          state_q, state_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic [PORCH_W-1:0]    porch_q, porch_d;
  logic [ADC_W-1:0]      blank_q, blank_d;
  logic [GOOD_W-1:0]     good_q, good_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic signed [ADC_W:0] video_q, video_d;
  logic                  vvalid_q;

  logic                  is_low;
  logic                  win_en, win_clear, win_done;
  logic [ADC_W-1:0]      win_avg, level_new;

  assign is_low = (adc_in < SYNC_THRESH);

  // Only high samples taken while measuring reach the window; anything else
  // on a valid cycle (including a sync dip mid-window) throws it away.
  assign win_en    = sample_valid && (state_q == ST_MEASURE) && !is_low;
  assign win_clear = sample_valid && ((state_q != ST_MEASURE) || is_low);

  window_averager #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_win (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .clear_i     (win_clear),
    .sample_en_i (win_en),
    .sample_i    (adc_in),
    .done_o      (win_done),
    .avg_o       (win_avg)
  );

`ifdef LEVEL_IIR_EN
  assign level_new = iir_step(blank_q, win_avg);
`else
  assign level_new = win_avg;
`endif

  // FSM next state, sync run length and porch down-counter.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    porch_d = porch_q;
    if (sample_valid) begin
      unique case (state_q)
        ST_SEEK: begin
          if (is_low) begin
            state_d = ST_SYNC;
            run_d   = RUN_ONE;
          end
        end
        ST_SYNC: begin
          if (is_low) begin
            if (run_q != RUN_SAT) run_d = run_q + RUN_ONE;
          end else begin
            run_d = '0;
            if ((run_q >= RUN_MIN) && (run_q <= RUN_MAX)) begin
              // The sample that ends sync is the first porch sample.
              if (PORCH_DELAY <= 1) begin
                state_d = ST_MEASURE;
              end else begin
                state_d = ST_PORCH;
                porch_d = PORCH_LOAD;
              end
            end else begin
              state_d = ST_SEEK;
            end
          end
        end
        ST_PORCH: begin
          if (is_low) begin
            state_d = ST_SYNC;
            run_d   = RUN_ONE;
          end else if (porch_q <= PORCH_ONE) begin
            state_d = ST_MEASURE;
          end else begin
            porch_d = porch_q - PORCH_ONE;
          end
        end
        ST_MEASURE: begin
          if (is_low) begin
            state_d = ST_SYNC;
            run_d   = RUN_ONE;
          end else if (win_done) begin
            state_d = ST_SEEK;
          end
        end
        default: state_d = ST_SEEK;
      endcase
    end
  end

  // Blank level, good-line count and the line timeout.
  always_comb begin
    blank_d = blank_q;
    good_d  = good_q;
    tmo_d   = tmo_q;
    if (sample_valid) begin
      if (win_done) begin
        blank_d = level_new;
        tmo_d   = '0;
        if (good_q != GOOD_SAT) good_d = good_q + GOOD_W'(1);
      end else if (tmo_q != TMO_SAT) begin
        tmo_d = tmo_q + TMO_W'(1);
        if (tmo_q == TMO_LAST) good_d = '0;
      end
    end
  end

  // Clamped output sample; the old blank level applies to the completing sample.
  assign video_d = $signed({1'b0, adc_in}) - $signed({1'b0, blank_q});

  // State, counters, level and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= ST_SEEK;
      run_q    <= '0;
      porch_q  <= '0;
      blank_q  <= BLANK_INIT;
      good_q   <= '0;
      tmo_q    <= '0;
      video_q  <= '0;
      vvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      porch_q  <= porch_d;
      blank_q  <= blank_d;
      good_q   <= good_d;
      tmo_q    <= tmo_d;
      vvalid_q <= sample_valid;
      if (sample_valid) video_q <= video_d;
    end
  end

  assign video_out    = video_q;
  assign video_valid  = vvalid_q;
  assign sync_tip     = (state_q == ST_SYNC) && (run_q >= RUN_MIN);
  assign blank_level  = blank_q;
  assign level_locked = (good_q == GOOD_SAT);

endmodule

// File: tb/tb_video_level_clamp.sv
// Testbench for video_level_clamp: a table of input segments with the
// expected level/lock/sync state after each, a scoreboard for every output
// sample, and a hand-written reset-mid-window sequence.
module tb_video_level_clamp;

  logic               sys_clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic               sample_valid = 1'b0;
  logic [11:0]        adc_in = '0;
  logic signed [12:0] video_out;
  logic               video_valid;
  logic               sync_tip;
  logic [11:0]        blank_level;
  logic               level_locked;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_blank = 2048;
  int sb[$];

  typedef struct {
    int n;
    int val;
    bit upd;
    int avg;
    bit lock;
    bit tip;
  } seg_t;

  seg_t segs[$];

  video_level_clamp dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .sample_valid (sample_valid),
    .adc_in       (adc_in),
    .video_out    (video_out),
    .video_valid  (video_valid),
    .sync_tip     (sync_tip),
    .blank_level  (blank_level),
    .level_locked (level_locked)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic int next_blank(input int old, input int avg);
    int d, q;
    d = avg - old;
    q = (d >= 0) ? d / 8 : -((-d + 7) / 8);
`ifdef LEVEL_IIR_EN
    return old + q;
`else
    return old + d;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic add(input int n, input int val, input bit upd, input int avg,
                     input bit lock, input bit tip);
    seg_t s;
    s.n = n; s.val = val; s.upd = upd; s.avg = avg; s.lock = lock; s.tip = tip;
    segs.push_back(s);
  endtask

  // One clock: drive inputs, then check the output that the edge produced.
  task automatic step(input bit v, input int d);
    int e;
    sample_valid = v;
    adc_in       = 12'(d);
    if (v) sb.push_back(d - exp_blank);
    @(posedge sys_clk);
    #1;
    chk("video_valid", int'(video_valid), int'(v));
    if (video_valid) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL scoreboard: video_valid with no expected sample");
      end else begin
        e = sb.pop_front();
        chk("video_out", int'(video_out), e);
      end
    end
    sample_valid = 1'b0;
  endtask

  task automatic send(input int n, input int val);
    for (int i = 0; i < n; i++) begin
      step(1'b1, val);
      if ($urandom_range(0, 7) == 0) step(1'b0, 0);
    end
  endtask

  initial begin
    // Spec line: sync 100, porch 120, window at 1000, then picture at 1500.
    add(100, 300, 0, 0, 0, 1);  add(120, 1100, 0, 0, 0, 0);
    add(32, 1000, 1, 1000, 0, 0); add(2000, 1500, 0, 0, 0, 0);
    // Short sync.
    add(40, 300, 0, 0, 0, 0);   add(200, 1500, 0, 0, 0, 0);
    // 257-sample run: sync_tip from sample 64, rejected as broad.
    add(63, 300, 0, 0, 0, 0);   add(1, 300, 0, 0, 0, 1);
    add(193, 300, 0, 0, 0, 1);  add(200, 1500, 0, 0, 0, 0);
    // 300-sample broad sync.
    add(300, 300, 0, 0, 0, 1);  add(200, 1500, 0, 0, 0, 0);
    // Minimum accepted sync (64).
    add(64, 300, 0, 0, 0, 1);   add(120, 1100, 0, 0, 0, 0);
    add(32, 800, 1, 800, 0, 0); add(100, 1500, 0, 0, 0, 0);
    // Maximum accepted sync (256), with a dip at porch sample 50.
    add(256, 300, 0, 0, 0, 1);  add(49, 1100, 0, 0, 0, 0);
    add(1, 300, 0, 0, 0, 0);    add(99, 300, 0, 0, 0, 1);
    add(120, 1100, 0, 0, 0, 0); add(32, 1000, 1, 1000, 0, 0);
    add(100, 1500, 0, 0, 0, 0);
    // Dip mid-window discards it; fourth window locks; then timeout.
    add(100, 300, 0, 0, 0, 1);  add(120, 1100, 0, 0, 0, 0);
    add(16, 2000, 0, 0, 0, 0);  add(1, 300, 0, 0, 0, 0);
    add(99, 300, 0, 0, 0, 1);   add(120, 1100, 0, 0, 0, 0);
    add(32, 1000, 1, 1000, 1, 0);
    add(4095, 1500, 0, 0, 1, 0); add(1, 1500, 0, 0, 0, 0);
    // After timeout the good-line count restarts from zero.
    add(100, 300, 0, 0, 0, 1);  add(120, 1100, 0, 0, 0, 0);
    add(32, 1000, 1, 1000, 0, 0);

    // Reset state.
    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst video_out", int'(video_out), 0);
    chk("rst video_valid", int'(video_valid), 0);
    chk("rst sync_tip", int'(sync_tip), 0);
    chk("rst blank_level", int'(blank_level), 2048);
    chk("rst level_locked", int'(level_locked), 0);
    sys_rst = 1'b0;

    foreach (segs[k]) begin
      send(segs[k].n, segs[k].val);
      if (segs[k].upd) exp_blank = next_blank(exp_blank, segs[k].avg);
      chk($sformatf("seg%0d blank_level", k), int'(blank_level), exp_blank);
      chk($sformatf("seg%0d level_locked", k), int'(level_locked), int'(segs[k].lock));
      chk($sformatf("seg%0d sync_tip", k), int'(sync_tip), int'(segs[k].tip));
    end

    // Reset asserted halfway through a measure window.
    send(100, 300);
    send(120, 1100);
    send(16, 1000);
    #2 sys_rst = 1'b1;
    #1;
    chk("midrst video_out", int'(video_out), 0);
    chk("midrst video_valid", int'(video_valid), 0);
    chk("midrst sync_tip", int'(sync_tip), 0);
    chk("midrst blank_level", int'(blank_level), 2048);
    chk("midrst level_locked", int'(level_locked), 0);
    sb.delete();
    exp_blank = 2048;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    // Rest of the abandoned window must not produce an update.
    send(16, 1000);
    send(100, 1500);
    chk("post-rst blank_level", int'(blank_level), 2048);
    chk("post-rst sync_tip", int'(sync_tip), 0);
    // A full line after reset measures normally.
    send(100, 300);
    send(120, 1100);
    send(32, 1000);
    exp_blank = next_blank(exp_blank, 1000);
    chk("post-rst line blank_level", int'(blank_level), exp_blank);
    send(4, 1500);
    chk("scoreboard drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
